// File: rtl/usr_pkg.sv
// usr_pkg: mode codes and FSM state encoding shared by the parametrised shift engine.
package usr_pkg;
  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_SHR   = 3'd2;
  localparam logic [2:0] MODE_SHL   = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_ROL   = 3'd5;
  localparam logic [2:0] MODE_ASR   = 3'd6;
  localparam logic [2:0] MODE_BURST = 3'd7;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
endpackage

// File: rtl/usr_barrel_shift.sv
// usr_barrel_shift: combinational next value for the multi-bit shift and rotate modes.
module usr_barrel_shift
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   value,
  input  logic [2:0]         mode,
  input  logic [SHIFT_W-1:0] amount,
  input  logic               fill_left,
  input  logic               fill_right,
  output logic [WIDTH-1:0]   result
);
  logic               over;
  logic [SHIFT_W-1:0] n_s, n_r;
  logic [WIDTH-1:0]   shr, shl, ror, rol, asr;
  // amounts past the top only occur for non-power-of-2 widths: saturate shifts, wrap rotates
  assign over = {1'b0, amount} >= (SHIFT_W+1)'(WIDTH);
  assign n_s  = over ? SHIFT_W'(WIDTH-1) : amount;
  assign n_r  = over ? amount - SHIFT_W'(WIDTH) : amount;
  assign shr  = WIDTH'({{WIDTH{fill_left}}, value} >> n_s);
  assign shl  = WIDTH'(({value, {WIDTH{fill_right}}} << n_s) >> WIDTH);
  assign ror  = WIDTH'({value, value} >> n_r);
  assign rol  = WIDTH'(({value, value} << n_r) >> WIDTH);
  assign asr  = WIDTH'({{WIDTH{value[WIDTH-1]}}, value} >> n_s);
  always_comb
    result = mode == MODE_SHR ? shr :
             mode == MODE_SHL ? shl :
             mode == MODE_ROR ? ror :
             mode == MODE_ROL ? rol :
             mode == MODE_ASR ? asr : value;
endmodule

// File: rtl/usr_param_shift_engine.sv
// usr_param_shift_engine: parametrised universal shift register with handshake and counted serial burst.
module usr_param_shift_engine
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               Clk_In,
  input  logic               Reset_In,
  input  logic               Cmd_Valid_In,
  output logic               Cmd_Ready_Out,
  input  logic [2:0]         USR_Mode_In,
  input  logic [SHIFT_W-1:0] Shift_Amount_In,
  input  logic               Serial_Data_Left_In,
  input  logic               Serial_Data_Right_In,
  input  logic [WIDTH-1:0]   Parallel_Data_In,
  output logic               Serial_Data_Right_Out,
  output logic               Serial_Data_Left_Out,
  output logic [WIDTH-1:0]   Parallel_Data_Out,
  output logic               Busy_Out,
  output logic               Done_Out
);
  state_t             state;
  logic [WIDTH-1:0]   data, shifted;
  logic [SHIFT_W-1:0] count;
  logic               done;
  usr_barrel_shift #(.WIDTH(WIDTH)) u_shift (
    .value(data),
    .mode(USR_Mode_In),
    .amount(Shift_Amount_In),
    .fill_left(Serial_Data_Left_In),
    .fill_right(Serial_Data_Right_In),
    .result(shifted)
  );
  always_ff @(negedge Clk_In or posedge Reset_In)
    if (Reset_In) begin
      state <= IDLE;
      data  <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (Cmd_Valid_In && USR_Mode_In == MODE_BURST) begin
          data  <= {Serial_Data_Left_In, data[WIDTH-1:1]};
          count <= SHIFT_W'(WIDTH-1);
          state <= BURST;
        end else if (Cmd_Valid_In)
          data <= USR_Mode_In == MODE_LOAD ? Parallel_Data_In : shifted;
      end else begin
        data  <= {Serial_Data_Left_In, data[WIDTH-1:1]};
        count <= count - 1'b1;
        if (count == SHIFT_W'(1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  assign Cmd_Ready_Out         = state == IDLE;
  assign Busy_Out              = state == BURST;
  assign Done_Out              = done;
  assign Parallel_Data_Out     = data;
  assign Serial_Data_Right_Out = data[0];
  assign Serial_Data_Left_Out  = data[WIDTH-1];
endmodule
